// File: rtl/seq_chk_pkg.sv
// Shared types and defaults for the sequence-checker verdict collector.
// State encoding is fixed so the debug state output is stable across builds.
package seq_chk_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    HALTED   = 2'd2,
    CLEARING = 2'd3
  } vc_state_e;

  localparam int CNT_W_DEF = 16;
  localparam int TS_W_DEF  = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/seq_verdict_collector.sv
// Collects match/fail verdicts from sequence checkers: saturating statistics, first-fail
// timestamp, per-attempt watchdog, fail-limit IRQ and a 4-phase clear handshake.
module seq_verdict_collector
  import seq_chk_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int TS_W       = TS_W_DEF,
  parameter int FAIL_LIMIT = 1,
  parameter int TIMEOUT    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arm,
  input  logic             en,
  input  logic             match,
  input  logic             fail,
  input  logic             clr_req,
  output logic             clr_ack,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] tmo_cnt,
  output logic [TS_W-1:0]  first_fail_ts,
  output logic             first_fail_vld,
  output logic             irq,
  output logic [1:0]       state
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(FAIL_LIMIT);
  localparam logic [WD_W-1:0]  WD_LOAD = WD_W'(TIMEOUT);

  vc_state_e        state_q, state_d;
  logic [TS_W-1:0]  ts_q;
  logic [WD_W-1:0]  wd_q;
  logic             armed, clr, match_inc, fail_inc, tmo_inc, verdict;
  logic [CNT_W-1:0] fail_cnt_next;

  assign armed     = (state_q == ARMED);
  assign clr       = (state_d == CLEARING);
  assign verdict   = match | fail;
  assign match_inc = armed && match;
  assign fail_inc  = armed && fail;
  // Watchdog expires on the cycle its last remaining tick elapses with no verdict or reload.
  assign tmo_inc   = armed && !en && !verdict && (wd_q == WD_W'(1));

  assign fail_cnt_next = (fail_inc && (fail_cnt != {CNT_W{1'b1}})) ? fail_cnt + CNT_W'(1)
                                                                   : fail_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr_req && (state_q != CLEARING)) begin
      state_d = CLEARING;
    end else begin
      case (state_q)
        CLEARING: if (!clr_req) state_d = IDLE;
        IDLE:     if (arm) state_d = ARMED;
        ARMED: begin
          if (!arm)                          state_d = IDLE;
          else if (fail_cnt_next >= LIMIT)   state_d = HALTED;
        end
        HALTED:   state_d = HALTED;
        default:  state_d = IDLE;
      endcase
    end
  end

  // Timestamp, first-fail capture and watchdog only advance while collecting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q           <= '0;
      first_fail_ts  <= '0;
      first_fail_vld <= 1'b0;
      wd_q           <= '0;
    end else if (clr) begin
      ts_q           <= '0;
      first_fail_ts  <= '0;
      first_fail_vld <= 1'b0;
      wd_q           <= '0;
    end else if (armed) begin
      ts_q <= ts_q + TS_W'(1);
      if (fail && !first_fail_vld) begin
        first_fail_ts  <= ts_q;
        first_fail_vld <= 1'b1;
      end
      if (en)                          wd_q <= WD_LOAD;
      else if (verdict)                wd_q <= '0;
      else if (wd_q != '0)             wd_q <= wd_q - WD_W'(1);
    end
  end

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk(clk), .rst_n(rst_n), .inc(match_inc), .clr(clr), .q(match_cnt)
  );
  sat_counter #(.W(CNT_W)) u_fail_cnt (
    .clk(clk), .rst_n(rst_n), .inc(fail_inc), .clr(clr), .q(fail_cnt)
  );
  sat_counter #(.W(CNT_W)) u_tmo_cnt (
    .clk(clk), .rst_n(rst_n), .inc(tmo_inc), .clr(clr), .q(tmo_cnt)
  );

  assign clr_ack = (state_q == CLEARING);
  assign irq     = (state_q == HALTED);
  assign state   = state_q;

endmodule

// File: tb/tb_seq_verdict_collector.sv
// Directed bench for seq_verdict_collector with a per-cycle reference model and scoreboard.
module tb_seq_verdict_collector;

  localparam int CNT_W      = 4;
  localparam int TS_W       = 32;
  localparam int FAIL_LIMIT = 2;
  localparam int TIMEOUT    = 8;
  localparam int CMAX       = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic arm = 0, en = 0, match = 0, fail = 0, clr_req = 0;
  logic             clr_ack, first_fail_vld, irq;
  logic [CNT_W-1:0] match_cnt, fail_cnt, tmo_cnt;
  logic [TS_W-1:0]  first_fail_ts;
  logic [1:0]       state;

  seq_verdict_collector #(
    .CNT_W(CNT_W), .TS_W(TS_W), .FAIL_LIMIT(FAIL_LIMIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .en(en), .match(match), .fail(fail),
    .clr_req(clr_req), .clr_ack(clr_ack), .match_cnt(match_cnt), .fail_cnt(fail_cnt),
    .tmo_cnt(tmo_cnt), .first_fail_ts(first_fail_ts), .first_fail_vld(first_fail_vld),
    .irq(irq), .state(state)
  );

  // ---------------- reference model ----------------
  // st: 0 idle, 1 armed, 2 halted, 3 clearing. wd = cycles left for the open attempt (0 = none).
  typedef struct packed {
    int          st;
    int          mc;
    int          fc;
    int          tc;
    int          wd;
    logic [31:0] ts;
    logic [31:0] ffts;
    logic        ffv;
  } model_t;

  model_t m;

  function automatic int sat_add(int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  function automatic model_t model_step(model_t s, logic a, logic e, logic mt, logic fl,
                                        logic cr);
    model_t n = s;
    if (cr && s.st != 3) begin
      n = '0;
      n.st = 3;
    end else if (s.st == 3) begin
      n = '0;
      n.st = cr ? 3 : 0;
    end else if (s.st == 0) begin
      if (a) n.st = 1;
    end else if (s.st == 1) begin
      if (fl && !s.ffv) begin
        n.ffts = s.ts;
        n.ffv  = 1'b1;
      end
      if (mt) n.mc = sat_add(s.mc);
      if (fl) n.fc = sat_add(s.fc);
      if (e) n.wd = TIMEOUT;
      else if (s.wd > 0) begin
        if (mt || fl) n.wd = 0;
        else begin
          n.wd = s.wd - 1;
          if (n.wd == 0) n.tc = sat_add(s.tc);
        end
      end
      n.ts = s.ts + 32'd1;
      if (!a)                     n.st = 0;
      else if (n.fc >= FAIL_LIMIT) n.st = 2;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= model_step(m, arm, en, match, fail, clr_req);
  end

  // ---------------- scoreboard ----------------
  int  n_vec = 0;
  int  n_err = 0;
  bit  chk_on = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      chk("state", state, m.st);
      chk("clr_ack", clr_ack, (m.st == 3));
      chk("irq", irq, (m.st == 2));
      chk("match_cnt", match_cnt, m.mc);
      chk("fail_cnt", fail_cnt, m.fc);
      chk("tmo_cnt", tmo_cnt, m.tc);
      chk("first_fail_vld", first_fail_vld, m.ffv);
      chk("first_fail_ts", first_fail_ts, m.ffts);
    end
  end

  // ---------------- driver ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    arm = 0;
    clr_req = 1;
    step(1);
    chk("clr_ack_high", clr_ack, 1);
    chk("clr_state", state, 3);
    chk("clr_match_cnt", match_cnt, 0);
    chk("clr_fail_cnt", fail_cnt, 0);
    chk("clr_irq", irq, 0);
    chk("clr_vld", first_fail_vld, 0);
    clr_req = 0;
    step(1);
    chk("clr_ack_low", clr_ack, 0);
    chk("clr_idle", state, 0);
  endtask

  initial begin
    // reset and reset values
    step(3);
    rst_n = 1;
    chk_on = 1;
    chk("rst_state", state, 0);
    chk("rst_match", match_cnt, 0);

    // async reset mid-count
    arm = 1;
    step(1);
    match = 1;
    step(3);
    chk("pre_rst_match", match_cnt, 3);
    #2 rst_n = 0;
    #1;
    chk("async_state", state, 0);
    chk("async_match", match_cnt, 0);
    chk("async_irq", irq, 0);
    chk("async_vld", first_fail_vld, 0);
    match = 0;
    arm = 0;
    step(1);
    rst_n = 1;
    step(1);

    // three match pulses while armed
    arm = 1;
    step(1);
    for (int i = 0; i < 3; i++) begin
      match = 1; step(1);
      match = 0; step(1);
    end
    chk("t2_match", match_cnt, 3);
    chk("t2_fail", fail_cnt, 0);
    chk("t2_irq", irq, 0);
    chk("t2_state", state, 1);
    do_clear();

    // fails at ts=5 and ts=9 reach the limit
    arm = 1;
    step(1);
    step(5);
    fail = 1; step(1); fail = 0;
    chk("t3_state_mid", state, 1);
    step(3);
    fail = 1; step(1); fail = 0;
    chk("t3_ffts", first_fail_ts, 5);
    chk("t3_vld", first_fail_vld, 1);
    chk("t3_fail", fail_cnt, 2);
    chk("t3_irq", irq, 1);
    chk("t3_state", state, 2);
    match = 1; step(1); match = 0; step(1);
    chk("t3_match_frozen", match_cnt, 0);

    // clear out of HALTED
    do_clear();

    // watchdog expiry, then an attempt rescued by a match
    arm = 1;
    step(1);
    en = 1; step(1); en = 0;
    step(7);
    chk("t4_tmo_early", tmo_cnt, 0);
    step(1);
    chk("t4_tmo", tmo_cnt, 1);
    en = 1; step(1); en = 0;
    step(3);
    match = 1; step(1); match = 0;
    step(10);
    chk("t4_tmo_saved", tmo_cnt, 1);
    chk("t4_match", match_cnt, 1);

    // simultaneous match/fail, then saturation
    match = 1; fail = 1; step(1); match = 0; fail = 0;
    chk("t5_match_both", match_cnt, 2);
    chk("t5_fail_both", fail_cnt, 1);
    match = 1;
    step(20);
    match = 0;
    step(1);
    chk("t5_match_sat", match_cnt, 15);
    chk("t5_state", state, 1);

    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
